// File: rtl/wb_commit_stage_if.sv
// MEM -> WB handoff bundle: valid/allowin handshake plus the instruction payload.
interface wb_commit_stage_if #(
  parameter int DATA_W    = 32,
  parameter int EXC_W     = 6,
  parameter int CSR_NUM_W = 14
);
  logic                 mem_to_wb_valid;
  logic                 wb_allowin;
  logic [31:0]          mem_pc;
  logic                 mem_rf_we;
  logic [4:0]           mem_rf_waddr;
  logic [DATA_W-1:0]    mem_rf_wdata;
  logic                 mem_csr_we;
  logic [CSR_NUM_W-1:0] mem_csr_num;
  logic [DATA_W-1:0]    mem_csr_mask;
  logic [DATA_W-1:0]    mem_csr_wdata;
  logic [EXC_W-1:0]     mem_exc;
  logic                 mem_ertn;
  logic [31:0]          mem_badv;

  modport master (
    output mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_csr_we, mem_csr_num, mem_csr_mask, mem_csr_wdata,
           mem_exc, mem_ertn, mem_badv,
    input  wb_allowin
  );

  modport slave (
    input  mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_csr_we, mem_csr_num, mem_csr_mask, mem_csr_wdata,
           mem_exc, mem_ertn, mem_badv,
    output wb_allowin
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Single-entry writeback/commit stage: GPR/CSR commit, prioritised exception, flush.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_commit_stage #(
  parameter int DATA_W    = 32,
  parameter int EXC_W     = 6,
  parameter int CSR_NUM_W = 14,
  parameter int IDX_W     = (EXC_W > 1) ? $clog2(EXC_W) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_commit_stage_if.slave     mem,
  input  logic                 csr_busy,
  output logic                 wb_valid,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic [DATA_W-1:0]    csr_mask,
  output logic [DATA_W-1:0]    csr_wdata,
  output logic                 exc_valid,
  output logic [IDX_W-1:0]     exc_idx,
  output logic [31:0]          exc_pc,
  output logic [31:0]          exc_badv,
  output logic                 ertn_flush,
  output logic                 flush,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]          retire_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic                 csr_we;
    logic [CSR_NUM_W-1:0] csr_num;
    logic [DATA_W-1:0]    csr_mask;
    logic [DATA_W-1:0]    csr_wdata;
    logic [EXC_W-1:0]     exc;
    logic                 ertn;
    logic [31:0]          badv;
  } pl_t;

  state_t state_q, state_d;
  pl_t    pl_q, pl_d;

  logic has_exc, ready_go, commit, capture;
  logic [IDX_W-1:0] exc_idx_w;

  assign wb_valid = (state_q == FULL);
  assign has_exc  = |pl_q.exc;
  // Only a surviving CSR write waits on the CSR unit; an excepting one is dropped.
  assign ready_go = ~(pl_q.csr_we & ~has_exc & csr_busy);
  assign mem.wb_allowin = ~wb_valid | ready_go;
  assign commit   = wb_valid & ready_go;

  assign exc_valid  = commit & has_exc;
  assign ertn_flush = commit & pl_q.ertn & ~has_exc;
  assign flush      = exc_valid | ertn_flush;
  assign capture    = mem.mem_to_wb_valid & mem.wb_allowin & ~flush;

  always_comb begin
    exc_idx_w = '0;
    for (int i = EXC_W - 1; i >= 0; i--)
      if (pl_q.exc[i]) exc_idx_w = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    if (flush)               state_d = EMPTY;
    else if (mem.wb_allowin) state_d = mem.mem_to_wb_valid ? FULL : EMPTY;
    if (capture) begin
      pl_d.pc        = mem.mem_pc;
      pl_d.rf_we     = mem.mem_rf_we;
      pl_d.rf_waddr  = mem.mem_rf_waddr;
      pl_d.rf_wdata  = mem.mem_rf_wdata;
      pl_d.csr_we    = mem.mem_csr_we;
      pl_d.csr_num   = mem.mem_csr_num;
      pl_d.csr_mask  = mem.mem_csr_mask;
      pl_d.csr_wdata = mem.mem_csr_wdata;
      pl_d.exc       = mem.mem_exc;
      pl_d.ertn      = mem.mem_ertn;
      pl_d.badv      = mem.mem_badv;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= EMPTY;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
    end
  end

  assign rf_we     = commit & pl_q.rf_we & ~has_exc;
  assign rf_waddr  = pl_q.rf_waddr;
  assign rf_wdata  = pl_q.rf_wdata;
  // Held high through a stall; the CSR unit samples it when csr_busy drops.
  assign csr_we    = wb_valid & pl_q.csr_we & ~has_exc;
  assign csr_num   = pl_q.csr_num;
  assign csr_mask  = pl_q.csr_mask;
  assign csr_wdata = pl_q.csr_wdata;
  assign exc_idx   = exc_idx_w;
  assign exc_pc    = pl_q.pc;
  assign exc_badv  = pl_q.badv;

  assign debug_wb_pc       = pl_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = pl_q.rf_waddr;
  assign debug_wb_rf_wdata = 32'(pl_q.rf_wdata);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit & ~has_exc) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) retire_cnt_q <= '0;
    else         retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: directed instructions push expected commit
// events; a negedge monitor pops and compares whenever the stage writes or traps.
module tb_wb_commit_stage;
  localparam int DATA_W = 32, EXC_W = 6, CSR_NUM_W = 14, IDX_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic csr_busy = 1'b0;
  always #5 clk = ~clk;

  wb_commit_stage_if #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CSR_NUM_W(CSR_NUM_W)) mif ();

  logic                 wb_valid, rf_we, csr_we, exc_valid, ertn_flush, flush;
  logic [4:0]           rf_waddr, debug_wb_rf_wnum;
  logic [DATA_W-1:0]    rf_wdata, csr_mask, csr_wdata;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [IDX_W-1:0]     exc_idx;
  logic [31:0]          exc_pc, exc_badv, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]           debug_wb_rf_we;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]          retire_cnt;
`endif

  wb_commit_stage #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CSR_NUM_W(CSR_NUM_W)) dut (
    .clk(clk), .resetn(resetn), .mem(mif), .csr_busy(csr_busy),
    .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_num(csr_num), .csr_mask(csr_mask), .csr_wdata(csr_wdata),
    .exc_valid(exc_valid), .exc_idx(exc_idx), .exc_pc(exc_pc), .exc_badv(exc_badv),
    .ertn_flush(ertn_flush), .flush(flush),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    int          kind;  // 0 GPR, 1 CSR, 2 exception, 3 ertn
    logic [31:0] a, b, c;
  } evt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] cdata;
    logic [5:0]  exc;
    logic        ertn;
    logic [31:0] badv;
  } instr_t;

  evt_t exp_q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic void expect_evt(input int k, input logic [31:0] a, b, c);
    evt_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic mon(input int k, input logic [31:0] a, b, c);
    evt_t e;
    if (exp_q.size() == 0) begin
      nvec++; nmis++;
      $display("FAIL unexpected_evt kind %0d: got a=0x%0h, expected no event", k, a);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("evt%0d_kind", k), 32'(k), 32'(e.kind));
      chk($sformatf("evt%0d_a", k), a, e.a);
      chk($sformatf("evt%0d_b", k), b, e.b);
      chk($sformatf("evt%0d_c", k), c, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we)             mon(0, 32'(rf_waddr), rf_wdata, 32'(debug_wb_rf_we));
    if (csr_we && !csr_busy) mon(1, 32'(csr_num), csr_mask, csr_wdata);
    if (exc_valid)         mon(2, 32'(exc_idx), exc_pc, exc_badv);
    if (ertn_flush)        mon(3, debug_wb_pc, 32'(exc_valid), 32'(0));
  end

  function automatic instr_t gpr(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    instr_t i;
    i = '0; i.pc = pc; i.rf_we = 1'b1; i.waddr = a; i.wdata = d;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    mif.mem_pc = i.pc;       mif.mem_rf_we = i.rf_we;
    mif.mem_rf_waddr = i.waddr; mif.mem_rf_wdata = i.wdata;
    mif.mem_csr_we = i.csr_we;  mif.mem_csr_num = i.num;
    mif.mem_csr_mask = i.mask;  mif.mem_csr_wdata = i.cdata;
    mif.mem_exc = i.exc;     mif.mem_ertn = i.ertn;
    mif.mem_badv = i.badv;   mif.mem_to_wb_valid = 1'b1;
  endtask

  // Offer until accepted; returns at posedge+1 with the instruction in WB.
  task automatic send(input instr_t i, output int waits);
    int w;
    drive(i);
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (wb_allowin_s() && !flush) break;
    end
    waits = w;
    if (w == 20) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: got no accept in 20 cycles, expected accept");
    end
    @(posedge clk); #1;
    mif.mem_to_wb_valid = 1'b0;
  endtask

  function automatic logic wb_allowin_s();
    return mif.wb_allowin;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    int w;
    drive('0);
    mif.mem_to_wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_allowin", 32'(mif.wb_allowin), 1);
    chk("rst_outputs", 32'({rf_we, csr_we, exc_valid, ertn_flush, flush}), 0);
    chk("rst_exc_pc", exc_pc, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // back-to-back GPR stream
    for (int k = 1; k <= 4; k++) begin
      expect_evt(0, 32'(k), 32'(k * 32'h11), 32'hF);
      send(gpr(32'h1C000000 + 32'(4 * k), 5'(k), 32'(k * 32'h11)), w);
      chk($sformatf("stream_wait%0d", k), 32'(w), 0);
    end

    // CSR write stalled 3 cycles, next instruction queued behind it
    csr_busy = 1'b1;
    i = '0; i.pc = 32'h1C000040; i.csr_we = 1'b1; i.num = 14'h0006;
    i.mask = 32'hFFFFFFFF; i.cdata = 32'hA5;
    expect_evt(1, 32'h6, 32'hFFFFFFFF, 32'hA5);
    send(i, w);
    expect_evt(0, 32'd5, 32'h55, 32'hF);
    drive(gpr(32'h1C000044, 5'd5, 32'h55));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_csr_we", k), 32'(csr_we), 1);
      chk($sformatf("stall%0d_allowin", k), 32'(mif.wb_allowin), 0);
      chk($sformatf("stall%0d_pc", k), debug_wb_pc, 32'h1C000040);
      @(posedge clk); #1;
    end
    csr_busy = 1'b0;
    @(negedge clk);
    chk("release_csr_we", 32'(csr_we), 1);
    chk("release_allowin", 32'(mif.wb_allowin), 1);
    @(posedge clk); #1;
    mif.mem_to_wb_valid = 1'b0;

    // exception: lowest set bit wins, same-cycle offer is killed
    i = gpr(32'h1C000100, 5'd7, 32'h77);
    i.exc = 6'b010100; i.badv = 32'h8;
    expect_evt(2, 32'd2, 32'h1C000100, 32'h8);
    send(i, w);
    drive(gpr(32'h1C000104, 5'd8, 32'h88));
    @(negedge clk);
    chk("exc_flush", 32'(flush), 1);
    chk("exc_rf_we", 32'(rf_we), 0);
    @(posedge clk); #1;
    mif.mem_to_wb_valid = 1'b0;
    @(negedge clk);
    chk("exc_after_valid", 32'(wb_valid), 0);
    chk("exc_after_flush", 32'(flush), 0);

    // exception + ertn + CSR write with busy: no stall, no ertn, no CSR write
    csr_busy = 1'b1;
    i = '0; i.pc = 32'h1C000200; i.csr_we = 1'b1; i.num = 14'h0010;
    i.cdata = 32'h1; i.exc = 6'b100000; i.ertn = 1'b1; i.badv = 32'h30;
    expect_evt(2, 32'd5, 32'h1C000200, 32'h30);
    @(posedge clk); #1;
    send(i, w);
    @(negedge clk);
    chk("combo_exc_valid", 32'(exc_valid), 1);
    chk("combo_ertn_flush", 32'(ertn_flush), 0);
    chk("combo_csr_we", 32'(csr_we), 0);
    chk("combo_allowin", 32'(mif.wb_allowin), 1);
    @(posedge clk); #1;
    csr_busy = 1'b0;

    // plain ertn
    i = '0; i.pc = 32'h1C000300; i.ertn = 1'b1;
    expect_evt(3, 32'h1C000300, 32'h0, 32'h0);
    send(i, w);
    @(negedge clk);
    chk("ertn_flush", 32'(flush), 1);
    @(posedge clk); #1;

    // reset during a CSR stall
    csr_busy = 1'b1;
    i = '0; i.pc = 32'h1C000400; i.csr_we = 1'b1; i.num = 14'h0011; i.cdata = 32'h5A;
    send(i, w);
    @(negedge clk);
    chk("pre_rst_csr_we", 32'(csr_we), 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    csr_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_wb_valid", 32'(wb_valid), 0);
    chk("post_rst_csr_we", 32'(csr_we), 0);
    chk("post_rst_csr_num", 32'(csr_num), 0);
    chk("post_rst_pc", debug_wb_pc, 0);
    chk("post_rst_allowin", 32'(mif.wb_allowin), 1);
    @(posedge clk); #1;

`ifdef WB_RETIRE_CNT_EN
    force dut.retire_cnt_q = 32'hFFFFFFFE;
    @(posedge clk); #1;
    release dut.retire_cnt_q;
    expect_evt(0, 32'd9, 32'h99, 32'hF);
    send(gpr(32'h1C000500, 5'd9, 32'h99), w);
    i = gpr(32'h1C000504, 5'd10, 32'hAA); i.exc = 6'b000001; i.badv = 32'h4;
    expect_evt(2, 32'd0, 32'h1C000504, 32'h4);
    send(i, w);
    chk("retire_ffff", retire_cnt, 32'hFFFFFFFF);
    expect_evt(0, 32'd11, 32'hBB, 32'hF);
    send(gpr(32'h1C000508, 5'd11, 32'hBB), w);
    chk("retire_exc_hold", retire_cnt, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("retire_wrap", retire_cnt, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
